// File: rtl/nco_multi.sv
// nco_multi: time-multiplexed multi-channel quadrature NCO.
// One channel is serviced per i_ce in round-robin order. All channels share
// one full-wave sine ROM that is read through two ports (sin and cos).
module nco_multi #(
    parameter int NCH   = 4,
    parameter int LGTBL = 9,
    parameter int W     = 32,
    parameter int OW    = 12,
    localparam int LGNCH = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ld,
    input  logic             i_ld_off,
    input  logic [LGNCH-1:0] i_ld_ch,
    input  logic [W-1:0]     i_dphase,
    input  logic [W-1:0]     i_offset,
    input  logic             i_sync,
    input  logic             i_ce,
    output logic             o_valid,
    output logic [LGNCH-1:0] o_ch,
    output logic [OW-1:0]    o_sin,
    output logic [OW-1:0]    o_cos
);
    localparam int  STAGES = 2;
    localparam int  NSLOT  = 1 << LGNCH;  // pow2 so any ptr/i_ld_ch value indexes safely
    localparam int  TSZ    = 1 << LGTBL;
    localparam real PI     = 3.14159265358979323846;

    function automatic logic signed [OW-1:0] tbl_val(int k);
        real r;
        r = real'((2 ** (OW - 1)) - 1) * $sin(2.0 * PI * real'(k) / real'(TSZ));
        if (r >= 0.0) return OW'($rtoi(r + 0.5));
        return OW'($rtoi(r - 0.5));
    endfunction

    logic [OW-1:0] tbl [TSZ];
    for (genvar k = 0; k < TSZ; k++) begin : g_rom
        localparam logic signed [OW-1:0] V = tbl_val(k);
        assign tbl[k] = V;
    end

    logic [W-1:0]       step_r [NSLOT];
    logic [W-1:0]       off_r  [NSLOT];
    logic [W-1:0]       acc_r  [NSLOT];
    logic [LGNCH-1:0]   ptr;
    logic [STAGES:0]    vld_pipe;

    logic [LGNCH-1:0]   svc_ch, ptr_nxt;
    logic [W-1:0]       svc_acc, ph;
    logic [LGTBL-1:0]   idx;
    logic               ld_ok;

    logic [LGTBL-1:0]   s1_sin_idx, s1_cos_idx;
    logic [LGNCH-1:0]   s1_ch, s2_ch;
    logic [OW-1:0]      s2_sin, s2_cos;

    // Stage 0: sync forces channel 0 with a zero accumulator for this service.
    assign svc_ch  = i_sync ? '0 : ptr;
    assign svc_acc = i_sync ? '0 : acc_r[svc_ch];
    assign ph      = svc_acc + off_r[svc_ch];
    assign idx     = LGTBL'(ph >> (W - LGTBL));
    assign ptr_nxt = (svc_ch == LGNCH'(NCH - 1)) ? '0 : svc_ch + LGNCH'(1);
    assign ld_ok   = ({1'b0, i_ld_ch} < (LGNCH + 1)'(NCH));
    assign o_valid = vld_pipe[STAGES];

    // Per-channel step/offset registers; out-of-range channels are ignored.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                step_r[i] <= '0;
                off_r[i]  <= '0;
            end
        end else begin
            if (i_ld && ld_ok)     step_r[i_ld_ch] <= i_dphase;
            if (i_ld_off && ld_ok) off_r[i_ld_ch]  <= i_offset;
        end
    end

    // Accumulators and round-robin pointer; the service write overrides the sync clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NSLOT; i++) acc_r[i] <= '0;
            ptr <= '0;
        end else begin
            if (i_sync) begin
                for (int i = 0; i < NSLOT; i++) acc_r[i] <= '0;
                ptr <= '0;
            end
            if (i_ce) begin
                acc_r[svc_ch] <= svc_acc + step_r[svc_ch];
                ptr           <= ptr_nxt;
            end
        end
    end

    // Stages 1-3: index register, ROM read, output register; outputs hold when idle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_pipe   <= '0;
            s1_sin_idx <= '0;
            s1_cos_idx <= '0;
            s1_ch      <= '0;
            s2_sin     <= '0;
            s2_cos     <= '0;
            s2_ch      <= '0;
            o_sin      <= '0;
            o_cos      <= '0;
            o_ch       <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], i_ce};
            if (i_ce) begin
                s1_sin_idx <= idx;
                s1_cos_idx <= idx + LGTBL'(TSZ / 4);
                s1_ch      <= svc_ch;
            end
            if (vld_pipe[0]) begin
                s2_sin <= tbl[s1_sin_idx];
                s2_cos <= tbl[s1_cos_idx];
                s2_ch  <= s1_ch;
            end
            if (vld_pipe[1]) begin
                o_sin <= s2_sin;
                o_cos <= s2_cos;
                o_ch  <= s2_ch;
            end
        end
    end
endmodule

// File: tb/tb_nco_multi.sv
// Scoreboard bench for nco_multi: three builds (NCH=4, 3, 1) share stimulus.
module tb_nco_multi;
    localparam real PI = 3.14159265358979323846;
    localparam int  NC [3] = '{4, 3, 1};
    localparam int  LG [3] = '{2, 2, 1};

    typedef struct {
        int ch;
        int s;
        int c;
        int stamp;
    } exp_t;

    logic        clk = 0, rst = 0;
    logic        ld = 0, ld_off = 0, sync = 0, ce = 0;
    logic [2:0]  ld_ch = 0;
    logic [31:0] dphase = 0, offset = 0;

    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    exp_t sb [3][$];
    exp_t last [3];

    bit [31:0] m_step [3][4];
    bit [31:0] m_off  [3][4];
    bit [31:0] m_acc  [3][4];
    int        m_ptr  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal quantised sine of table position k (table of 512 entries, amplitude 2047).
    function automatic int tval(int k);
        real r;
        r = 2047.0 * $sin(2.0 * PI * real'(k) / 512.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return $rtoi(r - 0.5);
    endfunction

    task automatic check(int g, bit v, int ch, int s, int c);
        exp_t e;
        n_cmp++;
        if (v) begin
            if (sb[g].size() == 0) begin
                n_bad++;
                $display("FAIL spurious_valid dut%0d cyc %0d: o_valid=1 ch=%0d, expected no sample", g, cyc, ch);
            end else begin
                e = sb[g].pop_front();
                last[g] = e;
                if (e.stamp != cyc || e.ch != ch || e.s != s || e.c != c) begin
                    n_bad++;
                    $display("FAIL sample dut%0d cyc %0d: got ch=%0d sin=%0d cos=%0d, expected ch=%0d sin=%0d cos=%0d at cyc %0d",
                             g, cyc, ch, s, c, e.ch, e.s, e.c, e.stamp);
                end
            end
        end else begin
            if (sb[g].size() > 0 && sb[g][0].stamp <= cyc) begin
                n_bad++;
                $display("FAIL missing_valid dut%0d cyc %0d: o_valid=0, expected sample ch=%0d", g, cyc, sb[g][0].ch);
                void'(sb[g].pop_front());
            end else if (ch != last[g].ch || s != last[g].s || c != last[g].c) begin
                n_bad++;
                $display("FAIL hold dut%0d cyc %0d: got ch=%0d sin=%0d cos=%0d, expected held ch=%0d sin=%0d cos=%0d",
                         g, cyc, ch, s, c, last[g].ch, last[g].s, last[g].c);
            end
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int N = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
        localparam int L = (N > 1) ? $clog2(N) : 1;
        logic               v;
        logic [L-1:0]       ch;
        logic signed [11:0] s, c;

        nco_multi #(.NCH(N), .LGTBL(9), .W(32), .OW(12)) dut (
            .i_clk(clk), .i_reset(rst), .i_ld(ld), .i_ld_off(ld_off),
            .i_ld_ch(ld_ch[L-1:0]), .i_dphase(dphase), .i_offset(offset),
            .i_sync(sync), .i_ce(ce), .o_valid(v), .o_ch(ch), .o_sin(s), .o_cos(c)
        );

        always @(negedge clk) if (!rst) check(g, v, int'(ch), int'(s), int'(c));
    end

    // Apply one cycle of inputs and advance the reference model by one clock.
    task automatic drive(bit ce_i, bit sy, bit ld_i, bit lo_i, int lch, bit [31:0] dp, bit [31:0] of);
        ce = ce_i; sync = sy; ld = ld_i; ld_off = lo_i;
        ld_ch = 3'(lch); dphase = dp; offset = of;
        for (int d = 0; d < 3; d++) begin
            int ch, lc, ix;
            bit [31:0] a, ph;
            exp_t e;
            ch = 0; a = 0;
            if (ce_i) begin
                ch = sy ? 0 : m_ptr[d];
                a  = sy ? 32'd0 : m_acc[d][ch];
                ph = a + m_off[d][ch];
                ix = int'(ph >> 23);
                e.ch = ch; e.s = tval(ix); e.c = tval((ix + 128) % 512); e.stamp = cyc + 3;
                sb[d].push_back(e);
            end
            if (sy) begin
                for (int i = 0; i < 4; i++) m_acc[d][i] = 0;
                m_ptr[d] = 0;
            end
            if (ce_i) begin
                m_acc[d][ch] = a + m_step[d][ch];
                m_ptr[d] = (ch + 1) % NC[d];
            end
            lc = lch % (1 << LG[d]);
            if (lc < NC[d]) begin
                if (ld_i) m_step[d][lc] = dp;
                if (lo_i) m_off[d][lc]  = of;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic zero_check(string tag);
        int vals [3][4];
        vals[0] = '{int'(gd[0].v), int'(gd[0].ch), int'(gd[0].s), int'(gd[0].c)};
        vals[1] = '{int'(gd[1].v), int'(gd[1].ch), int'(gd[1].s), int'(gd[1].c)};
        vals[2] = '{int'(gd[2].v), int'(gd[2].ch), int'(gd[2].s), int'(gd[2].c)};
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (vals[d][0] != 0 || vals[d][1] != 0 || vals[d][2] != 0 || vals[d][3] != 0) begin
                n_bad++;
                $display("FAIL %s dut%0d: got valid=%0d ch=%0d sin=%0d cos=%0d, expected all 0",
                         tag, d, vals[d][0], vals[d][1], vals[d][2], vals[d][3]);
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_step[d][i] = 0; m_off[d][i] = 0; m_acc[d][i] = 0;
            end
            m_ptr[d] = 0;
            sb[d].delete();
            last[d] = '{0, 0, 0, 0};
        end
    endtask

    initial begin
        model_reset();
        #1 rst = 1;
        #1 zero_check("reset_state");
        @(negedge clk);
        @(negedge clk);
        #1 rst = 0;
        @(negedge clk);

        // Fixed offsets at quarter turns, zero step, continuous i_ce.
        drive(0, 0, 1, 1, 0, 0, 32'h0000_0000);
        drive(0, 0, 1, 1, 1, 0, 32'h4000_0000);
        drive(0, 0, 1, 1, 2, 0, 32'h8000_0000);
        drive(0, 0, 1, 1, 3, 0, 32'hC000_0000);
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0, 0);
        idle(4);

        // One table entry per ch0 service; full turn after 512 ch0 samples.
        drive(0, 0, 1, 1, 0, 32'h0080_0000, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2060; i++) drive(1, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Sparse i_ce: one in three for 40 cycles.
        for (int i = 0; i < 40; i++) drive((i % 3) == 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Sync with service after 10 samples, plus a same-cycle step load to ch0.
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 32'h0123_4567, 0);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 0, 0, 0);

        // Loads to out-of-range channels mixed with service.
        drive(1, 0, 1, 1, 5, 32'hDEAD_BEEF, 32'h1234_5678);
        drive(1, 0, 1, 1, 3, 32'h0BAD_F00D, 32'h7654_3210);
        drive(1, 0, 1, 1, 7, 32'h5555_5555, 32'hAAAA_AAAA);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, 0);

        // Randomised traffic with wrapping sums.
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 7)), $urandom, $urandom);

        // Asynchronous reset between edges while samples are in flight.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
        ce = 0; sync = 0; ld = 0; ld_off = 0;
        #2 rst = 1;
        #1 zero_check("reset_midrun");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1 rst = 0;
        @(negedge clk);
        drive(0, 0, 1, 1, 1, 32'h0200_0000, 32'h4000_0000);
        for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, 0, 0, 0);
        idle(6);

        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (sb[d].size() != 0) begin
                n_bad++;
                $display("FAIL drain dut%0d: %0d samples never emitted, expected 0", d, sb[d].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
